// File: rtl/trackball_pkg.sv
// Shared definitions for the mouse-to-trackball encoder: output encoding
// selectors, the quadrature Gray-code state set and the saturating
// accumulator update used by every axis.
package trackball_pkg;

   // Output encoding selectors for the MODE parameter
   localparam int MODE_DIRCLK = 0;
   localparam int MODE_QUAD   = 1;

   // Working width of the saturating adder; accumulators up to 30 bits fit
   localparam int SAT_W = 32;

   // Quadrature states named by their {A,B} value
   typedef enum logic [1:0] {
      QUAD_00 = 2'b00,
      QUAD_01 = 2'b01,
      QUAD_11 = 2'b11,
      QUAD_10 = 2'b10
   } quad_state_t;

   // Positive motion walks 00 -> 01 -> 11 -> 10 -> 00
   function automatic quad_state_t quad_next(input quad_state_t s);
      quad_state_t r;
      r = QUAD_00;
      case (s)
         QUAD_00: r = QUAD_01;
         QUAD_01: r = QUAD_11;
         QUAD_11: r = QUAD_10;
         QUAD_10: r = QUAD_00;
         default: r = QUAD_00;
      endcase
      return r;
   endfunction

   // Negative motion walks the same ring backwards
   function automatic quad_state_t quad_prev(input quad_state_t s);
      quad_state_t r;
      r = QUAD_00;
      case (s)
         QUAD_00: r = QUAD_10;
         QUAD_10: r = QUAD_11;
         QUAD_11: r = QUAD_01;
         QUAD_01: r = QUAD_00;
         default: r = QUAD_00;
      endcase
      return r;
   endfunction

   // acc + d - step, clamped symmetrically to +/-(2^(acc_w-1)-1) so the
   // most negative code is never produced and negation stays safe.
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] acc,
      input logic signed [SAT_W-1:0] d,
      input logic signed [SAT_W-1:0] step,
      input int                      acc_w
   );
      logic signed [SAT_W-1:0] sum;
      logic signed [SAT_W-1:0] lim;
      sum = acc + d - step;
      lim = (SAT_W'(1) <<< (acc_w - 1)) - SAT_W'(1);
      if (sum > lim) begin
         sum = lim;
      end else if (sum < -lim) begin
         sum = -lim;
      end
      return sum;
   endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: a signed saturating accumulator of pending motion,
// drained one count per divider tick, plus the output encoder
// (direction/clock or A/B quadrature, chosen by MODE).
module trackball_axis
   import trackball_pkg::*;
#(
   parameter int ACC_W = 12,
   parameter int MODE  = MODE_DIRCLK
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               pkt,
   input  logic               tick,
   input  logic signed [ACC_W:0] delta,
   output logic               trak_a,
   output logic               trak_b,
   output logic               busy
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W:0]   delta_eff;
   logic signed [1:0]       step;

   // A step is taken on a tick whenever motion is pending; the packet delta
   // and the step are folded into a single saturating update so neither is lost.
   always_comb begin
      step = 2'sb00;
      if (tick && (acc != '0)) begin
         step = acc[ACC_W-1] ? 2'sb11 : 2'sb01;
      end
      delta_eff = '0;
      if (pkt) begin
         delta_eff = delta;
      end
      acc_next = ACC_W'(sat_add(SAT_W'(acc), SAT_W'(delta_eff), SAT_W'(step), ACC_W));
   end

   // Accumulator and busy flag advance together so busy always reflects acc
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         busy <= 1'b0;
      end else begin
         acc  <= acc_next;
         busy <= (acc_next != '0);
      end
   end

   generate
      if (MODE == MODE_QUAD) begin : g_quad
         quad_state_t q;

         // Walk the Gray ring one position per step in the step's direction
         always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
               q <= QUAD_00;
            end else if (step == 2'sb01) begin
               q <= quad_next(q);
            end else if (step == 2'sb11) begin
               q <= quad_prev(q);
            end
         end

         assign trak_a = q[1];
         assign trak_b = q[0];
      end else begin : g_dirclk
         logic dir_q;
         logic clk_q;

         // Direction is latched with each step and the clock line toggles once per step
         always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
               dir_q <= 1'b0;
               clk_q <= 1'b0;
            end else if (step != 2'sb00) begin
               dir_q <= ~acc[ACC_W-1];
               clk_q <= ~clk_q;
            end
         end

         assign trak_a = dir_q;
         assign trak_b = clk_q;
      end
   endgenerate

endmodule

// File: rtl/trackball_quad_gen.sv
// Mouse-to-trackball encoder top level. Detects packet toggles on
// mouse_stb, forms signed (optionally flipped) per-axis deltas, runs the
// shared step-rate divider and instantiates one trackball_axis per axis.
// Optional build macro TRACKBALL_ACCEL_EN doubles any delta whose
// magnitude exceeds ACCEL_THRESH before accumulation.
module trackball_quad_gen
   import trackball_pkg::*;
#(
   parameter int AXES         = 2,
   parameter int DELTA_W      = 8,
   parameter int ACC_W        = 12,
   parameter int DIV_W        = 8,
   parameter int MODE         = MODE_DIRCLK,
   parameter int ACCEL_THRESH = 16
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    mouse_stb,
   input  logic [AXES*DELTA_W-1:0] mouse_delta,
   input  logic [AXES-1:0]         mouse_sign,
   input  logic                    flip,
   input  logic                    enable,
   input  logic [DIV_W-1:0]        rate,
   output logic [AXES-1:0]         trak_a,
   output logic [AXES-1:0]         trak_b,
   output logic [AXES-1:0]         busy
);

   logic             stb_d;
   logic             pkt;
   logic             tick;
   logic [DIV_W-1:0] div_cnt;

   // Remember the last strobe level; any difference is a new packet
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         stb_d <= 1'b0;
      end else begin
         stb_d <= mouse_stb;
      end
   end

   assign pkt = mouse_stb ^ stb_d;

   // Reload on >= rather than == so lowering rate mid-count cannot strand
   // the counter above the new terminal value.
   assign tick = enable && (div_cnt >= rate);

   // Step-rate divider, frozen while the encoder is disabled
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (enable) begin
         if (tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

`ifdef TRACKBALL_ACCEL_EN
   localparam logic signed [ACC_W:0] ACCEL_LIM = (ACC_W+1)'(ACCEL_THRESH);
`else
   logic accel_unused;
   assign accel_unused = (ACCEL_THRESH != 0);
`endif

   genvar i;
   generate
      for (i = 0; i < AXES; i++) begin : g_axis
         logic signed [DELTA_W:0] raw;
         logic signed [ACC_W:0]   ext;
         logic signed [ACC_W:0]   d;

         // Widen by one bit beyond the accumulator so negating the most
         // negative input magnitude cannot overflow.
         always_comb begin
            raw = {mouse_sign[i], mouse_delta[i*DELTA_W +: DELTA_W]};
            ext = (ACC_W+1)'(raw);
            if (flip) begin
               ext = -ext;
            end
            d = ext;
`ifdef TRACKBALL_ACCEL_EN
            if ((ext > ACCEL_LIM) || (ext < -ACCEL_LIM)) begin
               d = ext <<< 1;
            end
`endif
         end

         trackball_axis #(
            .ACC_W (ACC_W),
            .MODE  (MODE)
         ) u_axis (
            .clk_sys (clk_sys),
            .reset   (reset),
            .pkt     (pkt),
            .tick    (tick),
            .delta   (d),
            .trak_a  (trak_a[i]),
            .trak_b  (trak_b[i]),
            .busy    (busy[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Testbench for trackball_quad_gen: one direction/clock instance and one
// quadrature instance share the same stimulus and are checked every cycle
// against a count-based motion model, with directed scenarios pinned by
// hand-computed values.
module tb_trackball_quad_gen;

   localparam int AXES         = 2;
   localparam int DELTA_W      = 8;
   localparam int ACC_W        = 12;
   localparam int DIV_W        = 8;
   localparam int ACCEL_THRESH = 16;
   localparam int ACC_MAX      = (1 << (ACC_W - 1)) - 1;

   logic                    clk_sys = 1'b0;
   logic                    reset = 1'b1;
   logic                    mouse_stb = 1'b0;
   logic [AXES*DELTA_W-1:0] mouse_delta = '0;
   logic [AXES-1:0]         mouse_sign = '0;
   logic                    flip = 1'b0;
   logic                    enable = 1'b0;
   logic [DIV_W-1:0]        rate = '0;
   logic [AXES-1:0]         dc_a, dc_b, dc_busy;
   logic [AXES-1:0]         qd_a, qd_b, qd_busy;

   int total = 0;
   int bad = 0;
   bit check_en = 1'b0;

   // Model state: pending counts, steps taken, ring position, last direction
   int m_acc   [AXES];
   int m_steps [AXES];
   int m_pos   [AXES];
   bit m_dir   [AXES];
   bit m_prev_stb = 1'b0;
   int m_div = 0;

   // Monitor counters
   int         tog_dc0 = 0;
   int         chg_all = 0;
   logic       mon_b0 = 1'b0;
   logic [7:0] mon_all = '0;

   always #5 clk_sys = ~clk_sys;

   trackball_quad_gen #(
      .AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W), .DIV_W(DIV_W),
      .MODE(0), .ACCEL_THRESH(ACCEL_THRESH)
   ) dut_dc (
      .clk_sys(clk_sys), .reset(reset), .mouse_stb(mouse_stb),
      .mouse_delta(mouse_delta), .mouse_sign(mouse_sign), .flip(flip),
      .enable(enable), .rate(rate), .trak_a(dc_a), .trak_b(dc_b), .busy(dc_busy)
   );

   trackball_quad_gen #(
      .AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W), .DIV_W(DIV_W),
      .MODE(1), .ACCEL_THRESH(ACCEL_THRESH)
   ) dut_qd (
      .clk_sys(clk_sys), .reset(reset), .mouse_stb(mouse_stb),
      .mouse_delta(mouse_delta), .mouse_sign(mouse_sign), .flip(flip),
      .enable(enable), .rate(rate), .trak_a(qd_a), .trak_b(qd_b), .busy(qd_busy)
   );

   // Signed delta of one axis as an ordinary integer
   function automatic int model_delta(int axis);
      int d;
      d = int'(mouse_delta[axis*DELTA_W +: DELTA_W]);
      if (mouse_sign[axis]) d = d - (1 << DELTA_W);
      if (flip) d = -d;
`ifdef TRACKBALL_ACCEL_EN
      if (d > ACCEL_THRESH || d < -ACCEL_THRESH) d = 2 * d;
`endif
      return d;
   endfunction

   // Direction/clock view: clock line is step-count parity, A is last direction
   function automatic logic [5:0] exp_dirclk();
      logic [1:0] ea, eb, ez;
      for (int a = 0; a < AXES; a++) begin
         ea[a] = m_dir[a];
         eb[a] = (m_steps[a] % 2) != 0;
         ez[a] = (m_acc[a] != 0);
      end
      return {ea, eb, ez};
   endfunction

   // Quadrature view: binary ring position converted to Gray code
   function automatic logic [5:0] exp_quad();
      logic [1:0] ea, eb, ez, p;
      for (int a = 0; a < AXES; a++) begin
         p = 2'(m_pos[a]);
         ea[a] = p[1];
         eb[a] = p[1] ^ p[0];
         ez[a] = (m_acc[a] != 0);
      end
      return {ea, eb, ez};
   endfunction

   task automatic check_vec(string name, logic [5:0] act, logic [5:0] req);
      total++;
      if (act !== req) begin
         bad++;
         if (bad <= 40) $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_int(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         if (bad <= 40) $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic wait_cycle();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic send_packet(int axis, bit sgn, logic [7:0] mag);
      mouse_delta = '0;
      mouse_sign  = '0;
      mouse_delta[axis*DELTA_W +: DELTA_W] = mag;
      mouse_sign[axis] = sgn;
      mouse_stb = ~mouse_stb;
      wait_cycle();
   endtask

   // Reference model, advanced on every clock edge and on reset assertion
   initial begin : model
      bit tick;
      bit pkt;
      int s;
      int nxt;
      forever begin
         @(posedge clk_sys or posedge reset);
         if (reset) begin
            for (int a = 0; a < AXES; a++) begin
               m_acc[a] = 0; m_steps[a] = 0; m_pos[a] = 0; m_dir[a] = 1'b0;
            end
            m_prev_stb = 1'b0;
            m_div = 0;
         end else begin
            tick = 1'b0;
            if (enable) begin
               if (m_div >= int'(rate)) begin
                  tick = 1'b1;
                  m_div = 0;
               end else begin
                  m_div++;
               end
            end
            pkt = (mouse_stb != m_prev_stb);
            for (int a = 0; a < AXES; a++) begin
               s = 0;
               if (tick && m_acc[a] != 0) s = (m_acc[a] > 0) ? 1 : -1;
               if (s != 0) begin
                  m_steps[a]++;
                  m_pos[a] = (m_pos[a] + s) & 3;
                  m_dir[a] = (s > 0);
               end
               nxt = m_acc[a] + (pkt ? model_delta(a) : 0) - s;
               if (nxt > ACC_MAX) nxt = ACC_MAX;
               if (nxt < -ACC_MAX) nxt = -ACC_MAX;
               m_acc[a] = nxt;
            end
            m_prev_stb = mouse_stb;
         end
      end
   end

   // Output-change monitor
   initial begin : monitor
      forever begin
         @(negedge clk_sys);
         if (dc_b[0] !== mon_b0) tog_dc0++;
         mon_b0 = dc_b[0];
         if ({dc_a, dc_b, qd_a, qd_b} !== mon_all) chg_all++;
         mon_all = {dc_a, dc_b, qd_a, qd_b};
      end
   end

   // Per-cycle comparison of both instances against the model
   initial begin : compare
      forever begin
         @(negedge clk_sys);
         if (check_en && !reset) begin
            check_vec("dirclk_cycle", {dc_a, dc_b, dc_busy}, exp_dirclk());
            check_vec("quad_cycle", {qd_a, qd_b, qd_busy}, exp_quad());
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int t0, prev_t, first, last, busy_cnt, a_bad, n, drop, cycles, steps0, c0;
      logic [1:0] seq [3];
      int at [3];
      logic [1:0] prev_q, cur;

      repeat (3) wait_cycle();
      check_vec("reset_dirclk", {dc_a, dc_b, dc_busy}, 6'b0);
      check_vec("reset_quad", {qd_a, qd_b, qd_busy}, 6'b0);
      reset = 1'b0; enable = 1'b1; rate = '0; check_en = 1'b1;
      wait_cycle();

      // +5 on axis 0 at full rate
      t0 = tog_dc0; prev_t = t0; first = -1; last = -1; busy_cnt = 0; a_bad = 0;
      send_packet(0, 1'b0, 8'd5);
      for (int i = 0; i < 12; i++) begin
         if (dc_busy[0]) busy_cnt++;
         if (tog_dc0 != prev_t) begin
            if (first < 0) first = i;
            last = i;
            if (!dc_a[0]) a_bad++;
         end
         prev_t = tog_dc0;
         wait_cycle();
      end
      check_int("p5_toggles", tog_dc0 - t0, 5);
      check_int("p5_busy_cycles", busy_cnt, 5);
      check_int("p5_span", last - first, 4);
      check_int("p5_dir_low", a_bad, 0);

      // -3 on axis 1 at rate 3, quadrature sequence
      rate = 8'd3;
      prev_q = {qd_a[1], qd_b[1]}; n = 0; drop = -1;
      send_packet(1, 1'b1, 8'hFD);
      for (int i = 0; i < 40; i++) begin
         cur = {qd_a[1], qd_b[1]};
         if (cur != prev_q) begin
            if (n < 3) begin seq[n] = cur; at[n] = i; end
            n++;
         end
         prev_q = cur;
         if (!qd_busy[1] && drop < 0) drop = i;
         wait_cycle();
      end
      check_int("q_changes", n, 3);
      check_int("q_seq0", int'(seq[0]), 2);
      check_int("q_seq1", int'(seq[1]), 3);
      check_int("q_seq2", int'(seq[2]), 1);
      check_int("q_spacing01", at[1] - at[0], 4);
      check_int("q_spacing12", at[2] - at[1], 4);
      check_int("q_busy_drop", drop, at[2]);

      // Flip: +4 becomes -4
      flip = 1'b1; rate = '0; t0 = tog_dc0;
      send_packet(0, 1'b0, 8'd4);
      repeat (10) wait_cycle();
      check_int("flip_toggles", tog_dc0 - t0, 4);
      check_int("flip_dir", int'(dc_a[0]), 0);
      flip = 1'b0;

      // Saturation: ten back-to-back +255 packets at rate 255
      rate = 8'd255; t0 = tog_dc0; steps0 = m_steps[0];
      for (int k = 0; k < 10; k++) send_packet(0, 1'b0, 8'hFF);
      check_int("sat_model_acc", m_acc[0], ACC_MAX);
      check_int("sat_busy", int'(dc_busy[0]), 1);
      rate = '0; a_bad = 0; cycles = 0;
      while (dc_busy[0] && cycles < 2600) begin
         wait_cycle();
         cycles++;
         if (tog_dc0 != t0 && !dc_a[0]) a_bad++;
      end
      wait_cycle();
      check_int("sat_drained", int'(dc_busy[0]), 0);
      check_int("sat_dir_high", a_bad, 0);
      check_int("sat_toggle_model", tog_dc0 - t0, m_steps[0] - steps0);
      check_int("sat_toggle_range", int'((tog_dc0 - t0) == 2047 || (tog_dc0 - t0) == 2048), 1);

      // Packet coincident with tick while acc = +1
      rate = 8'd3; cycles = 0;
      while (m_div != 0 && cycles < 10) begin wait_cycle(); cycles++; end
      t0 = tog_dc0;
      send_packet(0, 1'b0, 8'd1);
      check_int("coin_acc_first", m_acc[0], 1);
      wait_cycle(); wait_cycle();
      check_int("coin_phase", m_div, 3);
      send_packet(0, 1'b0, 8'd2);
      check_int("coin_acc_combined", m_acc[0], 2);
      check_int("coin_busy", int'(dc_busy[0]), 1);
      cycles = 0;
      while (dc_busy[0] && cycles < 40) begin wait_cycle(); cycles++; end
      wait_cycle();
      check_int("coin_steps", tog_dc0 - t0, 3);

      // Asynchronous reset in the middle of a burst
      rate = 8'd7;
      send_packet(0, 1'b0, 8'd40);
      repeat (4) wait_cycle();
      check_int("rst_pre_busy", int'(dc_busy[0]), 1);
      @(posedge clk_sys);
      #2;
      reset = 1'b1; mouse_stb = 1'b0; mouse_delta = '0; mouse_sign = '0;
      #1;
      check_vec("rst_async_dirclk", {dc_a, dc_b, dc_busy}, 6'b0);
      check_vec("rst_async_quad", {qd_a, qd_b, qd_busy}, 6'b0);
      wait_cycle(); wait_cycle();
      reset = 1'b0;
      c0 = chg_all;
      repeat (1000) wait_cycle();
      check_int("rst_quiet_changes", chg_all - c0, 0);
      check_vec("rst_quiet_busy", {dc_busy, qd_busy, 2'b00}, 6'b0);

      // Randomized traffic
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 250 == 0) rate = 8'($urandom_range(0, 3));
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) flip = ~flip;
         if ($urandom_range(0, 3) == 0) begin
            for (int a = 0; a < AXES; a++) begin
               if ($urandom_range(0, 7) == 0)
                  mouse_delta[a*DELTA_W +: DELTA_W] = 8'($urandom_range(0, 255));
               else
                  mouse_delta[a*DELTA_W +: DELTA_W] = 8'($urandom_range(0, 24));
               mouse_sign[a] = 1'($urandom_range(0, 1));
            end
            mouse_stb = ~mouse_stb;
         end
         wait_cycle();
      end
      enable = 1'b1; rate = '0; cycles = 0;
      while ((m_acc[0] != 0 || m_acc[1] != 0) && cycles < 5000) begin
         wait_cycle();
         cycles++;
      end
      wait_cycle();
      check_vec("drain_busy", {dc_busy, qd_busy, 2'b00}, 6'b0);

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
